// File: rtl/memory_responder_if.sv
// CPU memory handshake bundle: MOV/MOC request-complete pair plus access payload.
// The initiator (control unit) uses the master modport; the memory uses slave.
interface memory_responder_if;
    logic        MOV;
    logic        RW;
    logic [1:0]  SIZE;
    logic        SE;
    logic [31:0] ADDR;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        ERR;

    modport master (
        output MOV, RW, SIZE, SE, ADDR, DataIn,
        input  DataOut, MOC, ERR
    );

    modport slave (
        input  MOV, RW, SIZE, SE, ADDR, DataIn,
        output DataOut, MOC, ERR
    );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: target side of the MOV/MOC handshake backed by a
// byte-addressed big-endian RAM. MOC rises WAIT_CYCLES+1 edges after capture.
// Optional macro ALIGN_CHECK_EN: misaligned halfword/word accesses complete the
// handshake with ERR=1 and no RAM or DataOut update. When undefined, ERR is 0
// and misaligned accesses run as byte-wise accesses with address wrap.
module memory_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    memory_responder_if.slave   bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               moc_q, moc_d;
    logic               err_q, err_d;
    logic [31:0]        dout_q, dout_d;
    logic               cap_load_c;
    logic               access_c;

    logic [ADDR_W-1:0]  cap_addr;
    logic               cap_rw;
    logic [1:0]         cap_size;
    logic               cap_se;
    logic [31:0]        cap_din;

    logic [7:0]         mem [DEPTH];

    logic [ADDR_W-1:0]  lane_addr_c [LANES];
    logic [7:0]         lane_rd_c   [LANES];
    logic [7:0]         lane_wd_c   [LANES];
    logic [LANES-1:0]   lane_we_c;
    logic [31:0]        wr_aligned_c;
    logic [31:0]        rd_data_c;
    logic               ext_c;
    logic               misalign_c;

    // Per-byte addresses (wrapping) and big-endian lane data for the captured access
    always_comb begin
        wr_aligned_c = cap_din;
        case (cap_size)
            2'b00:   wr_aligned_c = {cap_din[7:0], 24'd0};
            2'b01:   wr_aligned_c = {cap_din[15:0], 16'd0};
            default: wr_aligned_c = cap_din;
        endcase
        for (int i = 0; i < int'(LANES); i++) begin
            lane_addr_c[i] = cap_addr + ADDR_W'(i);
            lane_rd_c[i]   = mem[lane_addr_c[i]];
            lane_wd_c[i]   = wr_aligned_c[31 - 8*i -: 8];
        end
    end

    // Alignment qualifier; constant 0 when alignment checking is not built in
`ifdef ALIGN_CHECK_EN
    always_comb begin
        misalign_c = 1'b0;
        case (cap_size)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = cap_addr[0];
            default: misalign_c = (cap_addr[1:0] != 2'b00);
        endcase
    end
`else
    always_comb begin
        misalign_c = 1'b0;
    end
`endif

    // Read data assembly with sign/zero extension
    always_comb begin
        ext_c     = cap_se & lane_rd_c[0][7];
        rd_data_c = {lane_rd_c[0], lane_rd_c[1], lane_rd_c[2], lane_rd_c[3]};
        case (cap_size)
            2'b00:   rd_data_c = {{24{ext_c}}, lane_rd_c[0]};
            2'b01:   rd_data_c = {{16{ext_c}}, lane_rd_c[0], lane_rd_c[1]};
            default: rd_data_c = {lane_rd_c[0], lane_rd_c[1], lane_rd_c[2], lane_rd_c[3]};
        endcase
    end

    // Byte-lane write enables for the access edge
    always_comb begin
        lane_we_c = '0;
        if (access_c && !cap_rw && !misalign_c) begin
            lane_we_c[0] = 1'b1;
            lane_we_c[1] = (cap_size != 2'b00);
            lane_we_c[2] = cap_size[1];
            lane_we_c[3] = cap_size[1];
        end
    end

    // Next-state and registered-output logic of the handshake FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        moc_d      = moc_q;
        err_d      = err_q;
        dout_d     = dout_q;
        cap_load_c = 1'b0;
        access_c   = 1'b0;
        case (state_q)
            IDLE: begin
                moc_d = 1'b0;
                err_d = 1'b0;
                if (bus.MOV) begin
                    cap_load_c = 1'b1;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (!bus.MOV) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access_c = 1'b1;
                    moc_d    = 1'b1;
                    err_d    = misalign_c;
                    if (cap_rw && !misalign_c) begin
                        dout_d = rd_data_c;
                    end
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                moc_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // FSM state, counter and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Request capture; held for the whole operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_addr <= '0;
            cap_rw   <= 1'b0;
            cap_size <= 2'b00;
            cap_se   <= 1'b0;
            cap_din  <= '0;
        end else if (cap_load_c) begin
            cap_addr <= bus.ADDR[ADDR_W-1:0];
            cap_rw   <= bus.RW;
            cap_size <= bus.SIZE;
            cap_se   <= bus.SE;
            cap_din  <= bus.DataIn;
        end
    end

    // RAM byte writes; contents survive reset, but reset blocks a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane_we_c[i]) begin
                    mem[lane_addr_c[i]] <= lane_wd_c[i];
                end
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.MOC     = moc_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (ADDR_W=9, WAIT_CYCLES=2).
// Latency is counted in edges from MOV assertion to MOC seen, capture edge included.
module tb_memory_responder;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    memory_responder_if bus();

    memory_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic rw, input logic [1:0] sz, input logic se,
                            input logic [31:0] a, input logic [31:0] d);
        bus.MOV    = 1'b1;
        bus.RW     = rw;
        bus.SIZE   = sz;
        bus.SE     = se;
        bus.ADDR   = a;
        bus.DataIn = d;
    endtask

    task automatic finish_op(input int hold, output logic [31:0] rdata,
                             output logic e, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            seen = bus.MOC;
        end
        rdata = bus.DataOut;
        e     = bus.ERR;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_moc", 32'(bus.MOC), 32'd1);
            check("hold_dout", bus.DataOut, rdata);
        end
        @(negedge clk);
        bus.MOV = 1'b0;
        @(posedge clk); #1;
        check("moc_drop", 32'(bus.MOC), 32'd0);
        check("err_drop", 32'(bus.ERR), 32'd0);
        @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        int          n;
        start_op(1'b0, sz, 1'b0, a, d);
        finish_op(0, r, e, n);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic rd(input string tag, input logic [1:0] sz, input logic se,
                      input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          n;
        start_op(1'b1, sz, se, a, 32'h0);
        finish_op(0, r, e, n);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          n;

        // Reset held low with a request pending
        reset = 1'b0;
        start_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h00221821);
        repeat (2) @(posedge clk);
        #1;
        check("rst_moc", 32'(bus.MOC), 32'd0);
        check("rst_dout", bus.DataOut, 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        finish_op(0, r, e, n);
        check("post_rst_lat", 32'(n), 32'd4);
        check("post_rst_dout", r, 32'd0);

        rd("rd_w10", 2'b10, 1'b0, 32'h10, 32'h00221821);

        wr("wr_b11", 2'b00, 32'h11, 32'h00000013);
        rd("rd_w10b", 2'b10, 1'b0, 32'h10, 32'h00131821);
        rd("rd_b11", 2'b00, 1'b0, 32'h11, 32'h00000013);

        wr("wr_h20", 2'b01, 32'h20, 32'h00008001);
        rd("rd_h20_se", 2'b01, 1'b1, 32'h20, 32'hFFFF8001);
        rd("rd_h20_ze", 2'b01, 1'b0, 32'h20, 32'h00008001);
        rd("rd_b20_se", 2'b00, 1'b1, 32'h20, 32'hFFFFFF80);
        rd("rd_b21_se", 2'b00, 1'b1, 32'h21, 32'h00000001);

        wr("wr_w30", 2'b10, 32'h30, 32'h11223344);
        check("wr_keeps_dout", bus.DataOut, 32'h00000001);

        // Abort: MOV dropped one cycle after capture
        start_op(1'b0, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        bus.MOV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_moc", 32'(bus.MOC), 32'd0);
        end
        check("abort_dout", bus.DataOut, 32'h00000001);
        @(negedge clk);
        rd("rd_w30_abort", 2'b10, 1'b0, 32'h30, 32'h11223344);

        // Reset while BUSY drops the pending write and clears DataOut
        start_op(1'b0, 2'b10, 1'b0, 32'h30, 32'h99999999);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_moc", 32'(bus.MOC), 32'd0);
        check("midrst_dout", bus.DataOut, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        bus.MOV = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd("rd_w30_rst", 2'b10, 1'b0, 32'h30, 32'h11223344);

        // Address/data changes after capture are ignored
        start_op(1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        bus.ADDR   = 32'h10;
        bus.DataIn = 32'h0;
        finish_op(0, r, e, n);
        check("cap_lat", 32'(n), 32'd3);
        rd("rd_w40", 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        rd("rd_w10_intact", 2'b10, 1'b0, 32'h10, 32'h00131821);

        // MOV held six cycles past MOC: one access, MOC held, then released
        start_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0);
        finish_op(6, r, e, n);
        check("hold_lat", 32'(n), 32'd4);
        check("hold_data", r, 32'h00000013);
        @(posedge clk); #1;
        check("hold_no_rerun", 32'(bus.MOC), 32'd0);
        @(negedge clk);

        // Upper address bits are ignored
        rd("rd_b211", 2'b00, 1'b0, 32'h211, 32'h00000013);

        // Misaligned word write at 0x31
        start_op(1'b0, 2'b10, 1'b0, 32'h31, 32'h55667788);
        finish_op(0, r, e, n);
        check("mis_lat", 32'(n), 32'd4);
`ifdef ALIGN_CHECK_EN
        check("mis_err", 32'(e), 32'd1);
        check("mis_dout", r, 32'h00000013);
        rd("rd_w30_mis", 2'b10, 1'b0, 32'h30, 32'h11223344);
`else
        check("mis_err", 32'(e), 32'd0);
        rd("rd_b31", 2'b00, 1'b0, 32'h31, 32'h00000055);
        rd("rd_b34", 2'b00, 1'b0, 32'h34, 32'h00000088);
        rd("rd_w30_mis", 2'b10, 1'b0, 32'h30, 32'h11556677);
        wr("wr_w1fe", 2'b10, 32'h1FE, 32'hA1B2C3D4);
        rd("rd_b000", 2'b00, 1'b0, 32'h000, 32'h000000C3);
        rd("rd_h1ff", 2'b01, 1'b0, 32'h1FF, 32'h0000B2C3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Target side of the CPU memory handshake: answers MOV requests from the control unit with MOC after a fixed number of wait states.
- Performs the access on internal byte-addressed, big-endian RAM for the instruction and data paths.
- Replaces the behavioural MOV/MOC memory model used in unit benches, so the control unit runs against synthesizable memory.

Parameters:
ADDR_W, 9, byte-address width of internal RAM (2^ADDR_W bytes); upper address bits ignored
WAIT_CYCLES, 2, extra cycles between request capture and MOC assertion (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
MOV  input  1  memory operation valid (request), level held by initiator until MOC seen
RW  input  1  1 = read, 0 = write
SIZE  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
SE  input  1  sign-extend byte/halfword reads when 1, zero-extend when 0
ADDR  input  32  byte address
DataIn  input  32  write data, right-justified (byte in [7:0], halfword in [15:0])
DataOut  output  32  read data, registered
MOC  output  1  memory operation complete
ERR  output  1  alignment error flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, MOC=0, DataOut=0, ERR=0, wait counter=0. RAM contents not cleared.
- States: IDLE, BUSY, DONE.
- IDLE: MOV==1 at edge k -> capture ADDR[ADDR_W-1:0], RW, SIZE, SE, DataIn; counter<=WAIT_CYCLES; go BUSY.
- BUSY, MOV==0: abort -> IDLE, no write, DataOut unchanged, MOC stays 0.
- BUSY, MOV==1, counter!=0: decrement counter.
- BUSY, MOV==1, counter==0: perform access; MOC<=1; go DONE.
- MOC first high after edge k+WAIT_CYCLES+1 (WAIT_CYCLES=2 -> 3 cycles).
- DONE: MOC held 1 while MOV==1. MOV==0 -> MOC<=0, go IDLE.
- New request needs MOV low for at least one edge: a request held high through DONE is not re-executed.
- Captured values are used for the whole operation; ADDR/DataIn changes after capture are ignored.
- Big-endian byte order: byte at address a drives bits [31:24] of the word at a.
- Word read: {m[a],m[a+1],m[a+2],m[a+3]}.
- Halfword read: {ext16, m[a], m[a+1]}.
- Byte read: {ext24, m[a]}.
- ext = replicated MSB of loaded data when SE=1, zeros otherwise.
- Writes store DataIn[7:0], DataIn[15:0] or DataIn[31:0] in the same order. Bytes outside the access size are untouched.
- Byte addresses a+1..a+3 wrap modulo 2^ADDR_W.
- Writes leave DataOut unchanged. DataOut updates only on the DONE transition of a read.
- Reset mid-operation: immediate IDLE, MOC=0. A pending write is dropped, and a write already performed stays in RAM.
- Reset has priority over every other input.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - Misaligned access = halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access still completes the handshake with identical timing.
  - ERR=1 together with MOC, for the whole DONE state; ERR clears with MOC.
  - No RAM write occurs and DataOut is unchanged.
- Undefined:
  - ERR tied to 0.
  - Misaligned accesses execute as sequential byte accesses with address wrap.

Test Plan:
- Reset low 2 cycles while MOV=1 -> MOC=0, DataOut=0, ERR=0, state IDLE; after reset rises, request captured on next edge.
- WAIT_CYCLES=2: word write 0x00221821 @0x10, drop MOV on MOC; word read @0x10 -> MOC rises 3 cycles after capture, DataOut=0x00221821.
- Write byte 0x13 (DataIn=0x00000013) @0x11.
  - Word read @0x10 -> 0x00131821.
  - Byte read @0x11, SE=0 -> 0x00000013.
- Write halfword 0x8001 @0x20.
  - Halfword read, SE=1 -> 0xFFFF8001.
  - Halfword read, SE=0 -> 0x00008001.
  - Byte read @0x20, SE=1 -> 0xFFFFFF80.
- Start word write 0xDEADBEEF @0x30, drop MOV after 1 cycle -> MOC never rises; word read @0x30 returns prior contents.
- Hold MOV high 6 cycles after MOC -> single access, MOC stays 1 until MOV low, then 0 next edge.
- With ALIGN_CHECK_EN: word write @0x31 -> ERR=1 with MOC, RAM unchanged.
- Without ALIGN_CHECK_EN: same write -> ERR=0, bytes stored at 0x31..0x34.
